// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RISC-V writeback stage driving the register-file write port
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mem_valid_i/ready_o   handshake with the MEM stage
//   mem_rd_idx_i, mem_rd_we_i, mem_is_load_i, mem_ld_funct3_i,
//   mem_addr_lo_i, mem_alu_res_i   retiring instruction fields
//   dmem_rvalid_i, dmem_rdata_i    data-memory read response
//   rf_wen_o (active-low), rf_rd_idx_o, rf_rd_wdata_o   register-file write port
//   retire_o              one-cycle pulse per retired or aborted instruction
//   err_o                 sticky error flag, cleared only by reset

module wb_stage #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [REG_AW-1:0] mem_rd_idx_i,
    input  logic              mem_rd_we_i,
    input  logic              mem_is_load_i,
    input  logic [2:0]        mem_ld_funct3_i,
    input  logic [1:0]        mem_addr_lo_i,
    input  logic [XLEN-1:0]   mem_alu_res_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              rf_wen_o,
    output logic [REG_AW-1:0] rf_rd_idx_o,
    output logic [XLEN-1:0]   rf_rd_wdata_o,
    output logic              retire_o,
    output logic              err_o
);

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Abort happens on the cycle the counter would reach LOAD_TIMEOUT.
    localparam logic [9:0] TIMEOUT_LAST = 10'(LOAD_TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT_LOAD
    } state_t;

    state_t              state_q, state_d;
    logic [9:0]          cnt_q, cnt_d;
    logic [REG_AW-1:0]   ld_rd_q;
    logic                ld_we_q;
    logic [2:0]          ld_f3_q;
    logic [1:0]          ld_lo_q;

    logic                latch_load;
    logic                do_write;
    logic                do_retire;
    logic                set_err;
    logic [REG_AW-1:0]   widx_d;
    logic [XLEN-1:0]     wdata_d;

    logic [XLEN-1:0]     ld_shift;
    logic [XLEN-1:0]     ld_data;
    logic                ld_ok;

    assign mem_ready_o = rst_n && (state_q == S_IDLE);

    // Move the addressed byte/halfword down to bit 0, then extend.
    always_comb begin
        ld_shift = dmem_rdata_i >> {ld_lo_q, 3'b000};
        ld_ok    = 1'b0;
        ld_data  = '0;
        case (ld_f3_q)
            F3_LB: begin
                ld_ok   = 1'b1;
                ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            end
            F3_LBU: begin
                ld_ok   = 1'b1;
                ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            end
            F3_LH: begin
                ld_ok   = ~ld_lo_q[0];
                ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            end
            F3_LHU: begin
                ld_ok   = ~ld_lo_q[0];
                ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            end
            F3_LW: begin
                ld_ok   = (ld_lo_q == 2'b00);
                ld_data = ld_shift;
            end
            default: begin
                ld_ok   = 1'b0;
                ld_data = '0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch_load = 1'b0;
        do_write   = 1'b0;
        do_retire  = 1'b0;
        set_err    = 1'b0;
        widx_d     = rf_rd_idx_o;
        wdata_d    = rf_rd_wdata_o;
        case (state_q)
            S_IDLE: begin
                // No load is outstanding, so any response is unexpected.
                if (dmem_rvalid_i) begin
                    set_err = 1'b1;
                end
                if (mem_valid_i) begin
                    if (mem_is_load_i) begin
                        latch_load = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_WAIT_LOAD;
                    end else begin
                        do_retire = 1'b1;
                        if (mem_rd_we_i && (mem_rd_idx_i != '0)) begin
                            do_write = 1'b1;
                            widx_d   = mem_rd_idx_i;
                            wdata_d  = mem_alu_res_i;
                        end
                    end
                end
            end
            S_WAIT_LOAD: begin
                if (dmem_rvalid_i) begin
                    do_retire = 1'b1;
                    state_d   = S_IDLE;
                    if (!ld_ok) begin
                        set_err = 1'b1;
                    end else if (ld_we_q && (ld_rd_q != '0)) begin
                        do_write = 1'b1;
                        widx_d   = ld_rd_q;
                        wdata_d  = ld_data;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    do_retire = 1'b1;
                    set_err   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ld_rd_q       <= '0;
            ld_we_q       <= 1'b0;
            ld_f3_q       <= '0;
            ld_lo_q       <= '0;
            rf_wen_o      <= 1'b1;
            rf_rd_idx_o   <= '0;
            rf_rd_wdata_o <= '0;
            retire_o      <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rf_wen_o <= ~do_write;
            retire_o <= do_retire;
            if (latch_load) begin
                ld_rd_q <= mem_rd_idx_i;
                ld_we_q <= mem_rd_we_i;
                ld_f3_q <= mem_ld_funct3_i;
                ld_lo_q <= mem_addr_lo_i;
            end
            if (do_write) begin
                rf_rd_idx_o   <= widx_d;
                rf_rd_wdata_o <= wdata_d;
            end
            if (set_err) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
